// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding and line constants for the UART transmitter
package uart_pkg;
   typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
   localparam int DATA_BITS = 8;
   localparam logic LINE_IDLE = 1'b1;
endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-period counter issuing a one-cycle tick on its last count
//  clk, rst : clock and synchronous active-high reset
//  i_clr    : restart the bit period from zero
//  o_tick   : high during the last cycle of each bit period
module uart_baud_tick #(
   parameter int CLOCKS_PER_PULSE = 5208
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clr,
   output logic o_tick
);
   localparam int CW = $clog2(CLOCKS_PER_PULSE);
   localparam logic [CW-1:0] LAST = CW'(CLOCKS_PER_PULSE - 1);
   logic [CW-1:0] r_cnt;
   assign o_tick = r_cnt == LAST;
   always_ff @(posedge clk)
      r_cnt <= (rst || i_clr || o_tick) ? '0 : r_cnt + 1'b1;
endmodule

// File: rtl/uart_transmitter.sv
// uart_transmitter: serialises bytes as start, 8 data bits LSB first, optional parity, stop bits
//  clk, rst  : clock and synchronous active-high reset
//  tx_valid  : producer offers tx_data
//  tx_data   : byte to send, sampled only on the accept cycle
//  tx_ready  : transmitter idle and able to accept
//  tx        : registered serial line, idles high
//  busy      : frame in progress
//  Macro UART_TX_PARITY_EN adds a parity bit whose sense is set by PARITY_ODD.
module uart_transmitter
   import uart_pkg::*;
#(
   parameter int CLOCKS_PER_PULSE = 5208,
   parameter int STOP_BITS        = 1,
   parameter int PARITY_ODD       = 0
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tx_valid,
   input  logic [7:0] tx_data,
   output logic       tx_ready,
   output logic       tx,
   output logic       busy
);
   localparam int BW = $clog2(DATA_BITS);
   localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
   localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
   tx_state_t r_state;
   logic [DATA_BITS-1:0] r_shift;
   logic [BW-1:0] r_bit;
   logic r_tx;
   logic w_tick;
   logic w_accept;
`ifdef UART_TX_PARITY_EN
   logic r_par;
`endif
   if (CLOCKS_PER_PULSE < 2 || STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
      $error("uart_transmitter: unsupported parameter set");
   end
   assign tx_ready = (r_state == TX_IDLE) && !rst;
   assign busy     = r_state != TX_IDLE;
   assign tx       = r_tx;
   assign w_accept = tx_valid && tx_ready;
   // Clearing on accept aligns the first bit period with the start bit.
   uart_baud_tick #(.CLOCKS_PER_PULSE(CLOCKS_PER_PULSE)) u_baud (
      .clk    (clk),
      .rst    (rst),
      .i_clr  (w_accept),
      .o_tick (w_tick)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= TX_IDLE;
         r_tx    <= LINE_IDLE;
         r_shift <= '0;
         r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
         r_par   <= 1'b0;
`endif
      end else begin
         case (r_state)
            TX_IDLE: if (w_accept) begin
               r_state <= TX_START;
               r_tx    <= 1'b0;
               r_shift <= tx_data;
               r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
               // Parity is taken now because the shift register is consumed bit by bit.
               r_par   <= (^tx_data) ^ (PARITY_ODD != 0);
`endif
            end
            TX_START: if (w_tick) begin
               r_state <= TX_DATA;
               r_tx    <= r_shift[0];
            end
            TX_DATA: if (w_tick) begin
               if (r_bit == LAST_DATA) begin
                  r_bit   <= '0;
`ifdef UART_TX_PARITY_EN
                  r_state <= TX_PARITY;
                  r_tx    <= r_par;
`else
                  r_state <= TX_STOP;
                  r_tx    <= LINE_IDLE;
`endif
               end else begin
                  r_bit   <= r_bit + 1'b1;
                  r_shift <= r_shift >> 1;
                  r_tx    <= r_shift[1];
               end
            end
`ifdef UART_TX_PARITY_EN
            TX_PARITY: if (w_tick) begin
               r_state <= TX_STOP;
               r_tx    <= LINE_IDLE;
            end
`endif
            TX_STOP: if (w_tick) begin
               r_bit   <= (r_bit == LAST_STOP) ? '0 : r_bit + 1'b1;
               r_state <= (r_bit == LAST_STOP) ? TX_IDLE : TX_STOP;
            end
            default: begin
               r_state <= TX_IDLE;
               r_tx    <= LINE_IDLE;
            end
         endcase
      end
   end
endmodule
